// File: rtl/dma_region_ac.sv
// Multi-region DMA access-control monitor: raises a registered core reset on protected-window
// access and re-arms at RESET_HANDLER. Optional violation log: DMA_AC_VIOLATION_LOG_EN.
module dma_region_ac #(
  parameter int unsigned                NUM_REGIONS   = 2,
  parameter logic [16*NUM_REGIONS-1:0]  REGION_BASE   = {16'hA000, 16'h6A00},
  parameter logic [16*NUM_REGIONS-1:0]  REGION_SIZE   = {16'h1000, 16'h0040},
  parameter logic [NUM_REGIONS-1:0]     REGION_WP     = 2'b10,
  parameter logic [15:0]                RESET_HANDLER = 16'h0000,
  parameter int unsigned                KILL_HOLD     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic        dma_we,
  input  logic        log_clr,
  output logic        reset,
  output logic        viol_valid,
  output logic [2:0]  viol_region,
  output logic [15:0] viol_addr,
  output logic [7:0]  viol_count
);

  typedef enum logic [1:0] {KILL, HOLD, ARM, RUN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  hold_cnt, hold_cnt_nxt;
  logic        viol;
  logic [2:0]  viol_idx;

  // Lowest-index violating region wins when windows overlap.
  always_comb begin
    viol     = 1'b0;
    viol_idx = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      logic [15:0] base, size, offs;
      base = REGION_BASE[16*i +: 16];
      size = REGION_SIZE[16*i +: 16];
      offs = dma_addr - base;
      if (!viol && dma_en && (size != '0) && (dma_addr >= base) && (offs < size) &&
          (!REGION_WP[i] || dma_we)) begin
        viol     = 1'b1;
        viol_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      KILL: begin
        hold_cnt_nxt = 8'(KILL_HOLD - 1);
        state_nxt    = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) state_nxt = ARM;
        else                hold_cnt_nxt = hold_cnt - 8'd1;
      end
      ARM:     if (pc == RESET_HANDLER && !viol) state_nxt = RUN;
      RUN:     if (viol) state_nxt = KILL;
      default: state_nxt = KILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= KILL;
      hold_cnt <= '0;
      reset    <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      reset    <= (state_nxt != RUN);
    end
  end

`ifdef DMA_AC_VIOLATION_LOG_EN
  logic        valid_nxt;
  logic [2:0]  region_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  count_nxt;

  // Clear is applied first so a same-cycle violation is recorded into a fresh log.
  always_comb begin
    valid_nxt  = viol_valid;
    region_nxt = viol_region;
    addr_nxt   = viol_addr;
    count_nxt  = viol_count;
    if (log_clr) begin
      valid_nxt  = 1'b0;
      region_nxt = '0;
      addr_nxt   = '0;
      count_nxt  = '0;
    end
    if (viol) begin
      if (count_nxt != '1) count_nxt = count_nxt + 8'd1;
      if (!valid_nxt) begin
        valid_nxt  = 1'b1;
        region_nxt = viol_idx;
        addr_nxt   = dma_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      viol_valid  <= 1'b0;
      viol_region <= '0;
      viol_addr   <= '0;
      viol_count  <= '0;
    end else begin
      viol_valid  <= valid_nxt;
      viol_region <= region_nxt;
      viol_addr   <= addr_nxt;
      viol_count  <= count_nxt;
    end
  end
`else
  logic unused_log;
  assign unused_log  = log_clr ^ (|viol_idx);
  assign viol_valid  = 1'b0;
  assign viol_region = '0;
  assign viol_addr   = '0;
  assign viol_count  = '0;
`endif

endmodule

// File: tb/tb_dma_region_ac.sv
// Bench for dma_region_ac: directed vectors, a run/elapsed-time reference model checked every
// cycle, plus literal expectations. Log checks follow DMA_AC_VIOLATION_LOG_EN.
module tb_dma_region_ac;

  localparam int unsigned NR  = 2;
  localparam logic [31:0] BASE = {16'hA000, 16'h6A00};
  localparam logic [31:0] SIZE = {16'h1000, 16'h0040};
  // Region 0 (6A00) write-only protected, region 1 (A000) protected against any access.
  localparam logic [1:0]  WP   = 2'b01;
  localparam logic [15:0] RH   = 16'h0000;
  localparam int          KH   = 4;
`ifdef DMA_AC_VIOLATION_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        dma_we;
  logic        log_clr;
  logic        reset;
  logic        viol_valid;
  logic [2:0]  viol_region;
  logic [15:0] viol_addr;
  logic [7:0]  viol_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  dma_region_ac #(
    .NUM_REGIONS(NR), .REGION_BASE(BASE), .REGION_SIZE(SIZE), .REGION_WP(WP),
    .RESET_HANDLER(RH), .KILL_HOLD(KH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .dma_addr(dma_addr), .dma_en(dma_en),
    .dma_we(dma_we), .log_clr(log_clr), .reset(reset), .viol_valid(viol_valid),
    .viol_region(viol_region), .viol_addr(viol_addr), .viol_count(viol_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: monitor is either running or counting edges since the last kill.
  bit          m_run;
  int          m_elapsed;
  bit          m_valid;
  int          m_region;
  logic [15:0] m_addr;
  int          m_count;

  function automatic void classify(input logic en, input logic we, input logic [15:0] a,
                                   output bit v, output int ri);
    v  = 1'b0;
    ri = 0;
    if (en) begin
      for (int r = NR - 1; r >= 0; r--) begin
        int b, s;
        b = int'(BASE[16*r +: 16]);
        s = int'(SIZE[16*r +: 16]);
        if (s != 0 && int'(a) >= b && int'(a) < b + s && (!WP[r] || we)) begin
          v  = 1'b1;
          ri = r;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit v;
    int ri;
    if (!reset_n) begin
      m_run = 1'b0; m_elapsed = 0;
      m_valid = 1'b0; m_region = 0; m_addr = '0; m_count = 0;
    end else begin
      classify(dma_en, dma_we, dma_addr, v, ri);
      if (m_run) begin
        if (v) begin m_run = 1'b0; m_elapsed = 0; end
      end else if (m_elapsed >= KH + 1 && pc == RH && !v) begin
        m_run = 1'b1;
      end else begin
        m_elapsed++;
      end
      if (LOG_EN) begin
        if (log_clr) begin m_valid = 1'b0; m_region = 0; m_addr = '0; m_count = 0; end
        if (v) begin
          m_count = (m_count < 255) ? m_count + 1 : 255;
          if (!m_valid) begin m_valid = 1'b1; m_region = ri; m_addr = dma_addr; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_reset",  32'(reset),       32'(!m_run));
      chk("model_valid",  32'(viol_valid),  32'(m_valid));
      chk("model_region", 32'(viol_region), 32'(m_region));
      chk("model_addr",   32'(viol_addr),   32'(m_addr));
      chk("model_count",  32'(viol_count),  32'(m_count));
    end
  end

  task automatic cyc(input logic en, input logic we, input logic [15:0] a,
                     input logic [15:0] p, input logic clr);
    dma_en = en; dma_we = we; dma_addr = a; pc = p; log_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Drives pc=RESET_HANDLER with no DMA and counts edges until reset drops.
  task automatic recover(input string name, input int exp_edges);
    int n;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b0, 1'b0, 16'h0000, RH, 1'b0);
      if (reset === 1'b0) begin n = k; break; end
    end
    chk(name, 32'(n), 32'(exp_edges));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; pc = 16'h1234; dma_addr = '0; dma_en = 1'b0; dma_we = 1'b0; log_clr = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("por_reset_high", 32'(reset), 32'd1);
    repeat (2) cyc(1'b0, 1'b0, 16'h0000, RH, 1'b0);
    reset_n = 1'b1;
    // T1: power-up behaves as a kill: reset deasserts on edge KH+2 after release.
    recover("t1_por_edges", KH + 2);

    // T2: read of the any-access window.
    cyc(1'b1, 1'b0, 16'hA800, 16'h1234, 1'b0);
    chk("t2_read_A800", 32'(reset), 32'd1);
    recover("t2_hold_edges", KH + 2);

    // T3: write-only window.
    cyc(1'b1, 1'b0, 16'h6A10, 16'h1234, 1'b0);
    chk("t3_read_6A10", 32'(reset), 32'd0);
    cyc(1'b1, 1'b1, 16'h6A10, 16'h1234, 1'b0);
    chk("t3_write_6A10", 32'(reset), 32'd1);
    recover("t3_hold_edges", KH + 2);
    cyc(1'b1, 1'b1, 16'h6A40, 16'h1234, 1'b0);
    chk("t3_write_6A40", 32'(reset), 32'd0);

    // T4: window boundaries.
    cyc(1'b1, 1'b1, 16'h9FFF, 16'h1234, 1'b0);
    chk("t4_9FFF", 32'(reset), 32'd0);
    cyc(1'b1, 1'b0, 16'hB000, 16'h1234, 1'b0);
    chk("t4_B000", 32'(reset), 32'd0);
    cyc(1'b1, 1'b0, 16'hA000, 16'h1234, 1'b0);
    chk("t4_A000", 32'(reset), 32'd1);
    recover("t4_hold_a", KH + 2);
    cyc(1'b1, 1'b0, 16'hAFFF, 16'h1234, 1'b0);
    chk("t4_AFFF", 32'(reset), 32'd1);
    recover("t4_hold_b", KH + 2);

    // dma_we without dma_en is ignored.
    cyc(1'b0, 1'b1, 16'hA000, 16'h1234, 1'b0);
    chk("no_en_write", 32'(reset), 32'd0);

    // Violation during KILL does not restart the hold.
    cyc(1'b1, 1'b0, 16'hA000, 16'h1234, 1'b0);
    cyc(1'b1, 1'b0, 16'hA010, RH, 1'b0);
    chk("kill_viol_reset", 32'(reset), 32'd1);
    recover("kill_viol_no_restart", KH + 1);

    // T5: violation coinciding with the handler pc keeps ARM.
    cyc(1'b1, 1'b0, 16'hA000, 16'h1234, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0);
    cyc(1'b1, 1'b0, 16'hA000, RH, 1'b0);
    chk("t5_arm_viol_stay", 32'(reset), 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, RH, 1'b0);
    chk("t5_arm_clean_run", 32'(reset), 32'd0);

    // Asynchronous reset in the middle of HOLD restarts the full sequence.
    cyc(1'b1, 1'b1, 16'h6A00, 16'h1234, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'(reset), 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, RH, 1'b0);
    reset_n = 1'b1;
    recover("midhold_reset_edges", KH + 2);

    // T6: violation log (tied off when the log is not built).
    cyc(1'b0, 1'b0, 16'h0000, 16'h1234, 1'b1);
    chk("t6_clr_count", 32'(viol_count), 32'd0);
    cyc(1'b1, 1'b0, 16'hA004, 16'h1234, 1'b0);
`ifdef DMA_AC_VIOLATION_LOG_EN
    chk("t6_first_valid", 32'(viol_valid), 32'd1);
    chk("t6_first_count", 32'(viol_count), 32'd1);
`endif
    recover("t6_hold_a", KH + 2);
    cyc(1'b1, 1'b1, 16'h6A02, 16'h1234, 1'b0);
`ifdef DMA_AC_VIOLATION_LOG_EN
    chk("t6_region", 32'(viol_region), 32'd1);
    chk("t6_addr",   32'(viol_addr),   32'hA004);
    chk("t6_count2", 32'(viol_count),  32'd2);
`else
    chk("t6_tied_valid", 32'(viol_valid), 32'd0);
`endif
    recover("t6_hold_b", KH + 2);
    cyc(1'b1, 1'b0, 16'hA000, 16'h1234, 1'b1);
`ifdef DMA_AC_VIOLATION_LOG_EN
    chk("t6_clr_viol_count", 32'(viol_count), 32'd1);
    chk("t6_clr_viol_addr",  32'(viol_addr),  32'hA000);
`endif

    // Count saturation while held in ARM.
    repeat (270) cyc(1'b1, 1'b0, 16'hA100, 16'h1234, 1'b0);
`ifdef DMA_AC_VIOLATION_LOG_EN
    chk("sat_count", 32'(viol_count), 32'hFF);
`else
    chk("tied_count", 32'(viol_count), 32'd0);
`endif
    recover("arm_to_run", 1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
